// File: rtl/riscv_encode.sv
// riscv_encode: assembles separated RISC-V instruction fields into a 32-bit
// word and queues it, paired with a sequential write address, in a small
// output FIFO for a program loader.
// Optional feature macro: RISCV_ENCODE_ILLEGAL_CHECK_EN. When defined, an
// `illegal` output is added, and bundles with opcode[1:0] != 2'b11 are
// consumed without being queued.
module riscv_encode #(
  parameter int              DEPTH     = 2,
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [6:0]                   opcode,
  input  logic [4:0]                   rd,
  input  logic [2:0]                   func,
  input  logic [4:0]                   rs1,
  input  logic [4:0]                   rs2,
  input  logic [6:0]                   funch,
  input  logic [11:0]                  imm12,
  input  logic [19:0]                  imm20,
  input  logic                         addr_clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  ins,
  output logic [ADDR_W-1:0]            out_addr,
  output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef RISCV_ENCODE_ILLEGAL_CHECK_EN
  ,
  output logic                         illegal
`endif
);

  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [31:0]       enc_p0;
  logic              acc_p0;
  logic              push_p0;
  logic              pop_p0;
  logic [ADDR_W-1:0] push_addr_p0;

  logic [31:0]       mem_ins  [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] addr_cnt;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Format select: the split format scatters imm12 so the decoder's
  // {ins[11:7], ins[31:25]} reassembles the original immediate.
  always_comb begin
    enc_p0 = {imm12, rs1, func, rd, opcode};
    unique case (opcode[6:2])
      5'b01101, 5'b00101, 5'b11011: enc_p0 = {imm20, rd, opcode};
      5'b01100, 5'b01110, 5'b01000: enc_p0 = {funch, rs2, rs1, func, rd, opcode};
      5'b11000:                     enc_p0 = {imm12[6:0], rs2, rs1, func, imm12[11:7], opcode};
      default:                      enc_p0 = {imm12, rs1, func, rd, opcode};
    endcase
  end

  assign in_ready     = (level < DEPTH_L);
  assign out_valid    = (level != '0);
  assign acc_p0       = in_valid && in_ready;
  assign pop_p0       = out_valid && out_ready;
  assign push_addr_p0 = addr_clear ? BASE_ADDR : addr_cnt;
`ifdef RISCV_ENCODE_ILLEGAL_CHECK_EN
  assign push_p0      = acc_p0 && (opcode[1:0] == 2'b11);
`else
  assign push_p0      = acc_p0;
`endif

  // ---- stage p1: FIFO storage; head is read straight from registers ----
  assign ins      = mem_ins[rd_ptr];
  assign out_addr = mem_addr[rd_ptr];

  // FIFO pointers, occupancy, address counter and storage update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      addr_cnt <= BASE_ADDR;
      for (int i = 0; i < DEPTH; i++) begin
        mem_ins[i]  <= '0;
        mem_addr[i] <= '0;
      end
    end else begin
      if (push_p0) begin
        mem_ins[wr_ptr]  <= enc_p0;
        mem_addr[wr_ptr] <= push_addr_p0;
        wr_ptr           <= ptr_next(wr_ptr);
        addr_cnt         <= push_addr_p0 + ADDR_W'(4);
      end else if (addr_clear) begin
        addr_cnt <= BASE_ADDR;
      end
      if (pop_p0) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      unique case ({push_p0, pop_p0})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef RISCV_ENCODE_ILLEGAL_CHECK_EN
  // One-cycle pulse after a bundle is dropped for a non-32-bit opcode
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal <= 1'b0;
    end else begin
      illegal <= acc_p0 && (opcode[1:0] != 2'b11);
    end
  end
`endif

endmodule

// File: tb/tb_riscv_encode.sv
// Directed and randomized bench for riscv_encode with a queue scoreboard.
module tb_riscv_encode;

  localparam int DEPTH = 2;
  localparam int ADDR_W = 8;
  localparam logic [7:0] BASE = 8'hF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  func;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funch;
  logic [11:0] imm12;
  logic [19:0] imm20;
  logic        addr_clear;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ins;
  logic [7:0]  out_addr;
  logic [1:0]  level;
`ifdef RISCV_ENCODE_ILLEGAL_CHECK_EN
  logic        illegal;
`endif

  riscv_encode #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .func(func), .rs1(rs1), .rs2(rs2),
    .funch(funch), .imm12(imm12), .imm20(imm20), .addr_clear(addr_clear),
    .out_valid(out_valid), .out_ready(out_ready), .ins(ins),
    .out_addr(out_addr), .level(level)
`ifdef RISCV_ENCODE_ILLEGAL_CHECK_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [7:0]  addr;
  } ent_t;

  ent_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_addr;
  logic [31:0] exp_next;
  logic        exp_ill;
  logic        last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder built from shifts and masks
  function automatic logic [31:0] model_enc(
    input logic [31:0] op, input logic [31:0] f_rd, input logic [31:0] f3,
    input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] f7,
    input logic [31:0] i12, input logic [31:0] i20);
    logic [4:0] m;
    m = op[6:2];
    if (m == 5'b01101 || m == 5'b00101 || m == 5'b11011)
      return (i20 << 12) | (f_rd << 7) | op;
    if (m == 5'b01100 || m == 5'b01110 || m == 5'b01000)
      return (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (f_rd << 7) | op;
    if (m == 5'b11000)
      return ((i12 & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | ((i12 >> 7) << 7) | op;
    return (i12 << 20) | (r1 << 15) | (f3 << 12) | (f_rd << 7) | op;
  endfunction

  task automatic put(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [6:0] f7,
                     input logic [11:0] i12, input logic [19:0] i20, input logic [31:0] e);
    opcode = op; rd = d; func = f3; rs1 = r1; rs2 = r2; funch = f7;
    imm12 = i12; imm20 = i20; exp_next = e; in_valid = 1'b1;
  endtask

  // Check status against the model, then advance one clock edge
  task automatic tick();
    bit acc;
    bit pop;
    chk("level", 32'(level), q.size());
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
`ifdef RISCV_ENCODE_ILLEGAL_CHECK_EN
    chk("illegal", 32'(illegal), 32'(exp_ill));
`endif
    last_acc = 1'b0;
    if (rst) begin
      q.delete();
      exp_addr = BASE;
      exp_ill = 1'b0;
    end else begin
      acc = in_valid && (q.size() < DEPTH);
      pop = out_ready && (q.size() != 0);
      if (pop) begin
        chk("ins", ins, q[0].ins);
        chk("out_addr", 32'(out_addr), 32'(q[0].addr));
        void'(q.pop_front());
      end
      exp_ill = 1'b0;
      if (acc) begin
        last_acc = 1'b1;
`ifdef RISCV_ENCODE_ILLEGAL_CHECK_EN
        if (opcode[1:0] != 2'b11) begin
          exp_ill = 1'b1;
          if (addr_clear) exp_addr = BASE;
        end else begin
          if (addr_clear) exp_addr = BASE;
          q.push_back('{ins: exp_next, addr: exp_addr});
          exp_addr = exp_addr + 8'd4;
        end
`else
        if (addr_clear) exp_addr = BASE;
        q.push_back('{ins: exp_next, addr: exp_addr});
        exp_addr = exp_addr + 8'd4;
`endif
      end else if (addr_clear) begin
        exp_addr = BASE;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && q.size() != 0; i++) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
    tick();
  endtask

  initial begin
    logic [6:0]  r_op;
    logic [4:0]  r_rd, r_r1, r_r2;
    logic [2:0]  r_f3;
    logic [6:0]  r_f7;
    logic [11:0] r_i12;
    logic [19:0] r_i20;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; addr_clear = 1'b0;
    opcode = '0; rd = '0; func = '0; rs1 = '0; rs2 = '0; funch = '0;
    imm12 = '0; imm20 = '0; exp_next = '0; exp_addr = BASE; exp_ill = 1'b0;
    last_acc = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tick();
    rst = 1'b0;
    chk("rst_ins", ins, 32'h0);
    chk("rst_addr", 32'(out_addr), 32'h0);

    // ADDI x1,x0,5
    out_ready = 1'b1;
    put(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 12'd5, 20'd0, 32'h00500093);
    tick();
    in_valid = 1'b0;
    chk("addi_lat_valid", 32'(out_valid), 32'd1);
    tick();

    // ADD x3,x1,x2 then LUI x5,0x12345 back to back (address wraps FC -> 00)
    put(7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 12'd0, 20'd0, 32'h002081B3);
    tick();
    put(7'b0110111, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 12'd0, 20'h12345, 32'h123452B7);
    tick();
    drain();

    // Branch with split immediate
    put(7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 12'hABC, 20'd0, 32'h78208AE3);
    tick();
    drain();

    // Backpressure: three bundles offered into a two-entry FIFO
    out_ready = 1'b0;
    put(7'b0010011, 5'd7, 3'd1, 5'd2, 5'd0, 7'd0, 12'h111, 20'd0,
        model_enc(32'h13, 32'd7, 32'd1, 32'd2, 32'd0, 32'd0, 32'h111, 32'd0));
    tick();
    put(7'b0110011, 5'd8, 3'd2, 5'd3, 5'd4, 7'h20, 12'd0, 20'd0,
        model_enc(32'h33, 32'd8, 32'd2, 32'd3, 32'd4, 32'h20, 32'd0, 32'd0));
    tick();
    put(7'b0010111, 5'd9, 3'd0, 5'd0, 5'd0, 7'd0, 12'd0, 20'hFEDCB,
        model_enc(32'h17, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFEDCB));
    tick();
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_full_level", 32'(level), 32'd2);
    out_ready = 1'b1;
    last_acc = 1'b0;
    for (int i = 0; i < 10 && !last_acc; i++) tick();
    chk("bp_third_accepted", 32'(last_acc), 32'd1);
    drain();

    // addr_clear coinciding with a push
    put(7'b0000011, 5'd4, 3'd2, 5'd6, 5'd0, 7'd0, 12'h7F0, 20'd0,
        model_enc(32'h03, 32'd4, 32'd2, 32'd6, 32'd0, 32'd0, 32'h7F0, 32'd0));
    addr_clear = 1'b1;
    tick();
    addr_clear = 1'b0;
    chk("clear_head_addr", 32'(out_addr), 32'(BASE));
    drain();

    // Randomized traffic with random backpressure and occasional clears
    for (int i = 0; i < 60; i++) begin
      r_op = 7'($urandom); r_rd = 5'($urandom); r_f3 = 3'($urandom);
      r_r1 = 5'($urandom); r_r2 = 5'($urandom); r_f7 = 7'($urandom);
      r_i12 = 12'($urandom); r_i20 = 20'($urandom);
      put(r_op, r_rd, r_f3, r_r1, r_r2, r_f7, r_i12, r_i20,
          model_enc(32'(r_op), 32'(r_rd), 32'(r_f3), 32'(r_r1), 32'(r_r2),
                    32'(r_f7), 32'(r_i12), 32'(r_i20)));
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      addr_clear = ($urandom_range(0, 9) == 0);
      tick();
    end
    addr_clear = 1'b0;
    drain();

    // Reset in the middle of a stream with the FIFO full
    out_ready = 1'b0;
    put(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 12'd1, 20'd0, 32'h00100093);
    tick();
    put(7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 12'd2, 20'd0, 32'h00200113);
    tick();
    chk("pre_rst_level", 32'(level), 32'd2);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("post_rst_ins", ins, 32'h0);
    chk("post_rst_addr", 32'(out_addr), 32'h0);
    tick();
    put(7'b0010011, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 12'd3, 20'd0, 32'h00300193);
    tick();
    in_valid = 1'b0;
    chk("post_rst_first_addr", 32'(out_addr), 32'(BASE));
    drain();

`ifdef RISCV_ENCODE_ILLEGAL_CHECK_EN
    // Non-32-bit opcode is consumed, not queued, and pulses illegal once
    out_ready = 1'b0;
    put(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 12'd9, 20'd0, 32'h00900093);
    tick();
    put(7'b0010010, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 12'd9, 20'd0, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_level", 32'(level), 32'd1);
    tick();
    chk("ill_one_shot", 32'(illegal), 32'd0);
    put(7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 12'd9, 20'd0, 32'h00900113);
    tick();
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/riscv_encode.md
Name: riscv_encode

Overview:
- Instruction encoder: the inverse of the team's combinational field decoder. It takes separated instruction fields and assembles the 32-bit RISC-V word using the same field layout the decoder splits apart.
- Feeds a program loader / instruction-memory writer through a small output FIFO. Each word is paired with a sequential write address.
- Valid/ready handshake on both sides. Fully registered output; no combinational in-to-out path.

Parameters:
- DEPTH, 2: output FIFO entries (must be ≥1).
- ADDR_W, 32: width of out_addr and the internal address counter.
- BASE_ADDR, 0: address assigned to the first word after reset or addr_clear.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- opcode  in  7  opcode; mode = opcode[6:2].
- rd  in  5  destination register.
- func  in  3  funct3.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- funch  in  7  funct7.
- imm12  in  12  12-bit immediate.
- imm20  in  20  20-bit upper immediate.
- addr_clear  in  1  restart the address counter at BASE_ADDR.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- ins  out  32  encoded word at the FIFO head.
- out_addr  out  ADDR_W  address paired with ins.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Format select by mode (field order below is MSB first):
  - U (modes 01101, 00101, 11011): ins = {imm20, rd, opcode}.
  - R (modes 01100, 01110, 01000): ins = {funch, rs2, rs1, func, rd, opcode}.
  - Split (mode 11000): ins = {imm12[6:0], rs2, rs1, func, imm12[11:7], opcode}.
    - This is the exact inverse of the decoder's imm12 = {ins[11:7], ins[31:25]}.
  - I (all other modes): ins = {imm12, rs1, func, rd, opcode}.
  - Fields not used by the selected format are ignored.
- Accept: in_valid && in_ready at a rising edge.
  - The encoded word and the current address counter value are pushed into the FIFO tail.
  - The counter then increments by 4, modulo 2^ADDR_W (wraps silently).
- in_ready = (level < DEPTH).
  - Registered-only: a pop in the same cycle does NOT raise in_ready when full.
- out_valid = (level != 0). ins/out_addr show the head entry and are held stable while out_valid && !out_ready.
- Pop: out_valid && out_ready at a rising edge.
- Simultaneous push and pop: level is unchanged and ordering is preserved.
- Latency: a bundle accepted at edge N is visible on out_valid/ins after edge N (i.e. during cycle N+1) when the FIFO was empty.
- addr_clear:
  - Counter is set to BASE_ADDR.
  - If a push occurs in the same cycle, that word takes BASE_ADDR and the counter becomes BASE_ADDR+4.
  - Entries already in the FIFO keep their addresses.
- Reset (also mid-operation):
  - FIFO is emptied: level=0, out_valid=0, in_ready=1, counter=BASE_ADDR.
  - ins=0 and out_addr=0 (head storage cleared).
  - Any in-flight handshake in the reset cycle is ignored.

Optional Feature:
- Macro: RISCV_ENCODE_ILLEGAL_CHECK_EN.
- Defined:
  - Adds output port illegal (1 bit, registered, reset 0).
  - An accepted bundle with opcode[1:0] != 2'b11 is consumed (handshake completes) but not pushed.
  - The address counter does not advance for that bundle.
  - illegal pulses high for exactly one cycle after the accepting edge.
- Undefined:
  - No illegal port.
  - All opcodes are encoded and pushed unchanged.

Test Plan:
- ADDI x1,x0,5 (opcode 0010011, rd=1, func=0, rs1=0, imm12=5), out_ready=1 → next cycle out_valid=1, ins=0x00500093, out_addr=0.
- ADD x3,x1,x2 (opcode 0110011, funch=0, rs2=2, rs1=1, rd=3), then LUI x5,0x12345 (opcode 0110111, rd=5) → ins=0x002081B3 then 0x123452B7, out_addr 0 then 4.
- Branch (opcode 1100011, func=0, rs1=1, rs2=2, imm12=0xABC) → ins=0x78208AE3; feeding it to the decoder returns imm12=0xABC.
- Backpressure (DEPTH=2, out_ready=0): offer 3 bundles → in_ready low after 2 accepts, level=2. Raise out_ready → words drain in order, 3rd accepted once level<2.
- Address wrap and clear (ADDR_W=8, BASE_ADDR=0xF8): 3 pushes → out_addr F8, FC, 00. addr_clear together with the 4th push → that word gets F8.
- Reset mid-stream with level=2 → next cycle level=0, out_valid=0, in_ready=1. Next word gets out_addr=BASE_ADDR. With the macro defined: opcode 0010010 → illegal pulses once, level unchanged.
